// File: rtl/can_pkg.sv
// Shared types and constants for the CAN receive-path error controller.
package can_pkg;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    FLAG    = 2'd1,
    WAIT    = 2'd2,
    DELIM   = 2'd3
  } can_err_state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_BIT   = 3'd1;
  localparam logic [2:0] ERR_STUFF = 3'd2;
  localparam logic [2:0] ERR_FORM  = 3'd3;
  localparam logic [2:0] ERR_CRC   = 3'd4;
  localparam logic [2:0] ERR_ACK   = 3'd5;
  localparam logic [2:0] ERR_EOF   = 3'd6;

  localparam logic [7:0] REC_SAT      = 8'd255;
  localparam logic [7:0] REC_SUCCESS  = 8'd120;
  localparam logic [7:0] REC_STEP     = 8'd8;
  localparam logic [7:0] REC_DECAY_TH = 8'd128;

  function automatic logic rec_is_passive(input logic [7:0] rec, input int unsigned th);
    return {24'd0, rec} >= th;
  endfunction

endpackage

// File: rtl/can_err_prio.sv
// Priority encoder over the active-low checker outputs: bit > stuff > form > CRC > ACK > EOF.
module can_err_prio
  import can_pkg::*;
(
  input  logic       i_bit_n,
  input  logic       i_stuff_n,
  input  logic       i_form_n,
  input  logic       i_crc_n,
  input  logic       i_ack_n,
  input  logic       i_eof_n,
  output logic [2:0] o_code
);

  always_comb begin
    o_code = ERR_NONE;
    if (!i_bit_n)        o_code = ERR_BIT;
    else if (!i_stuff_n) o_code = ERR_STUFF;
    else if (!i_form_n)  o_code = ERR_FORM;
    else if (!i_crc_n)   o_code = ERR_CRC;
    else if (!i_ack_n)   o_code = ERR_ACK;
    else if (!i_eof_n)   o_code = ERR_EOF;
  end

endmodule

// File: rtl/can_error_ctrl.sv
// CAN receive-path error controller: error-frame sequencing, REC and error-passive tracking.
//   state   | meaning
//   MONITOR | normal reception, watching checkers and Frame_Ok
//   FLAG    | driving the error flag (dominant unless error-passive)
//   WAIT    | waiting out flag superposition, penalising dominant bits
//   DELIM   | counting recessive delimiter bits
module can_error_ctrl
  import can_pkg::*;
#(
  parameter int FLAG_LEN   = 6,
  parameter int DELIM_LEN  = 8,
  parameter int PASSIVE_TH = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SP,
  input  logic       RX,
  input  logic       Bit_Error,
  input  logic       Stuff_Error,
  input  logic       Form_Error,
  input  logic       CRC_Error,
  input  logic       ACK_Error,
  input  logic       EOF_Error,
  input  logic       Frame_Ok,
  output logic       TX_Err,
  output logic       Chk_Clear,
  output logic [2:0] Err_Code,
  output logic       Err_Passive,
  output logic [7:0] REC,
  output logic       Err_Busy
);

  localparam logic [3:0] LP_FLAG_LAST  = 4'(FLAG_LEN - 1);
  localparam logic [3:0] LP_DELIM_LAST = 4'(DELIM_LEN - 1);

  can_err_state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_rec, w_rec_nxt;
  logic [2:0] r_code, w_code_nxt;
  logic       r_clear, w_clear_nxt;
  logic       r_fpass, w_fpass_nxt;
  logic       r_dom_seen, w_dom_seen_nxt;

  logic [2:0] w_err_code;
  logic [7:0] w_rec_inc;
  logic [8:0] w_rec_sum8;
  logic [7:0] w_rec_add8;

  can_err_prio u_prio (
    .i_bit_n   (Bit_Error),
    .i_stuff_n (Stuff_Error),
    .i_form_n  (Form_Error),
    .i_crc_n   (CRC_Error),
    .i_ack_n   (ACK_Error),
    .i_eof_n   (EOF_Error),
    .o_code    (w_err_code)
  );

  assign w_rec_inc  = (r_rec == REC_SAT) ? REC_SAT : r_rec + 8'd1;
  assign w_rec_sum8 = {1'b0, r_rec} + {1'b0, REC_STEP};
  assign w_rec_add8 = w_rec_sum8[8] ? REC_SAT : w_rec_sum8[7:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rec_nxt      = r_rec;
    w_code_nxt     = r_code;
    w_clear_nxt    = 1'b0;
    w_fpass_nxt    = r_fpass;
    w_dom_seen_nxt = r_dom_seen;
    if (SP) begin
      case (r_state)
        MONITOR: begin
          if (w_err_code != ERR_NONE) begin
            w_code_nxt  = w_err_code;
            w_rec_nxt   = w_rec_inc;
            w_clear_nxt = 1'b1;
            w_state_nxt = FLAG;
            w_cnt_nxt   = 4'd0;
            w_fpass_nxt = rec_is_passive(w_rec_inc, PASSIVE_TH);
          end else if (Frame_Ok) begin
            if (r_rec >= REC_DECAY_TH) w_rec_nxt = REC_SUCCESS;
            else if (r_rec != 8'd0)    w_rec_nxt = r_rec - 8'd1;
          end
        end
        FLAG: begin
          if (r_cnt == LP_FLAG_LAST) begin
            w_state_nxt    = WAIT;
            w_cnt_nxt      = 4'd0;
            w_dom_seen_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        WAIT: begin
          // cnt tracks dominant bits after the first one, in groups of eight
          if (RX) begin
            w_state_nxt = DELIM;
            w_cnt_nxt   = 4'd1;
          end else if (!r_dom_seen) begin
            w_rec_nxt      = w_rec_add8;
            w_dom_seen_nxt = 1'b1;
            w_cnt_nxt      = 4'd0;
          end else if (r_cnt == 4'd7) begin
            w_rec_nxt = w_rec_add8;
            w_cnt_nxt = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        DELIM: begin
          if (!RX) begin
            w_code_nxt  = ERR_FORM;
            w_rec_nxt   = w_rec_inc;
            w_clear_nxt = 1'b1;
            w_state_nxt = FLAG;
            w_cnt_nxt   = 4'd0;
            w_fpass_nxt = rec_is_passive(w_rec_inc, PASSIVE_TH);
          end else if (r_cnt == LP_DELIM_LAST) begin
            w_state_nxt = MONITOR;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        default: w_state_nxt = MONITOR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= MONITOR;
      r_cnt      <= 4'd0;
      r_rec      <= 8'd0;
      r_code     <= ERR_NONE;
      r_clear    <= 1'b0;
      r_fpass    <= 1'b0;
      r_dom_seen <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rec      <= w_rec_nxt;
      r_code     <= w_code_nxt;
      r_clear    <= w_clear_nxt;
      r_fpass    <= w_fpass_nxt;
      r_dom_seen <= w_dom_seen_nxt;
    end
  end

  assign TX_Err      = !((r_state == FLAG) && !r_fpass);
  assign Chk_Clear   = r_clear;
  assign Err_Code    = r_code;
  assign Err_Passive = rec_is_passive(r_rec, PASSIVE_TH);
  assign REC         = r_rec;
  assign Err_Busy    = (r_state != MONITOR);

endmodule
